// File: rtl/skid_buffer.sv
// skid_buffer: two-entry valid/ready pipeline stage that fully decouples the
// upstream and downstream handshakes. Every output comes from a flop, so there
// is no combinational path from any input to any output.
//
// Ports:
//   clk        single clock; all state updates on its rising edge
//   reset      synchronous, active-high; overrides any accept or take
//   in_valid   upstream presents in_data
//   in_ready   block can accept a word (registered)
//   in_data    upstream data word
//   out_valid  out_data holds a valid word (registered)
//   out_ready  downstream consumes the current word
//   out_data   head word, driven directly from the main register
//   count      occupancy 0..2 (registered)
//
// state | meaning
// ------+---------------------------------------------
// EMPTY | nothing held, in_ready=1, out_valid=0
// ONE   | main holds head word, in_ready=1, out_valid=1
// TWO   | main + skid hold words, in_ready=0, out_valid=1
module skid_buffer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  // Encoding matches the occupancy count.
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] main_nxt;
  logic [WIDTH-1:0] skid_nxt;
  logic             accept;
  logic             take;

  // Handshakes use the registered flags, so in_valid while in_ready=0 and
  // out_ready while out_valid=0 fall out as no-ops.
  assign accept = in_valid & in_ready;
  assign take   = out_valid & out_ready;

  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    case (state)
      EMPTY: begin
        if (accept) begin
          main_nxt  = in_data;
          state_nxt = ONE;
        end
      end
      ONE: begin
        if (accept && take) begin
          main_nxt = in_data;
        end else if (accept) begin
          skid_nxt  = in_data;
          state_nxt = TWO;
        end else if (take) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (take) begin
          main_nxt  = skid_q;
          state_nxt = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      count     <= 2'd0;
    end else begin
      state     <= state_nxt;
      main_q    <= main_nxt;
      skid_q    <= skid_nxt;
      // Flags are decoded from the next state so they stay pure flop outputs.
      in_ready  <= (state_nxt != TWO);
      out_valid <= (state_nxt == ONE) || (state_nxt == TWO);
      count     <= state_nxt;
    end
  end

  assign out_data = main_q;

endmodule

// File: tb/tb_skid_buffer.sv
module tb_skid_buffer;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       count;

  int vectors = 0;
  int errors  = 0;

  skid_buffer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD_BEEF; out_ready = 1'b1;
    tick();
    tick();
    vectors++;
    if ({out_valid, in_ready, count, out_data} !== {1'b0, 1'b1, 2'd0, 32'h0}) begin
      errors++;
      $display("FAIL reset: got v=%b r=%b c=%0d d=%h, want v=0 r=1 c=0 d=00000000",
               out_valid, in_ready, count, out_data);
    end
    // out_ready with nothing held must do nothing.
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    vectors++;
    if ({out_valid, in_ready, count} !== {1'b0, 1'b1, 2'd0}) begin
      errors++;
      $display("FAIL idle_take: got v=%b r=%b c=%0d, want v=0 r=1 c=0",
               out_valid, in_ready, count);
    end
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_data = 32'h0000_007F; out_ready = 1'b0;
    tick();
    vectors++;
    if ({out_valid, in_ready, count, out_data} !== {1'b1, 1'b1, 2'd1, 32'h7F}) begin
      errors++;
      $display("FAIL single: got v=%b r=%b c=%0d d=%h, want v=1 r=1 c=1 d=0000007f",
               out_valid, in_ready, count, out_data);
    end
  endtask

  task automatic test_fill_drain();
    in_data = 32'h0000_00FF;
    tick();
    vectors++;
    if ({out_valid, in_ready, count, out_data} !== {1'b1, 1'b0, 2'd2, 32'h7F}) begin
      errors++;
      $display("FAIL fill_two: got v=%b r=%b c=%0d d=%h, want v=1 r=0 c=2 d=0000007f",
               out_valid, in_ready, count, out_data);
    end
    in_data = 32'h0000_0001;
    tick();
    vectors++;
    if ({out_valid, in_ready, count, out_data} !== {1'b1, 1'b0, 2'd2, 32'h7F}) begin
      errors++;
      $display("FAIL ignore_full: got v=%b r=%b c=%0d d=%h, want v=1 r=0 c=2 d=0000007f",
               out_valid, in_ready, count, out_data);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    vectors++;
    if ({out_valid, in_ready, count, out_data} !== {1'b1, 1'b1, 2'd1, 32'hFF}) begin
      errors++;
      $display("FAIL drain_first: got v=%b r=%b c=%0d d=%h, want v=1 r=1 c=1 d=000000ff",
               out_valid, in_ready, count, out_data);
    end
    tick();
    vectors++;
    if ({out_valid, in_ready, count} !== {1'b0, 1'b1, 2'd0}) begin
      errors++;
      $display("FAIL drain_empty: got v=%b r=%b c=%0d, want v=0 r=1 c=0",
               out_valid, in_ready, count);
    end
  endtask

  task automatic test_stream();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data = i;
      tick();
      vectors++;
      if ({out_valid, in_ready, count, out_data} !== {1'b1, 1'b1, 2'd1, 32'(i)}) begin
        errors++;
        $display("FAIL stream[%0d]: got v=%b r=%b c=%0d d=%h, want v=1 r=1 c=1 d=%h",
                 i, out_valid, in_ready, count, out_data, 32'(i));
      end
    end
    in_valid = 1'b0;
    tick();
    vectors++;
    if ({out_valid, count} !== {1'b0, 2'd0}) begin
      errors++;
      $display("FAIL stream_end: got v=%b c=%0d, want v=0 c=0", out_valid, count);
    end
  endtask

  task automatic test_reset_in_two();
    in_valid = 1'b1; out_ready = 1'b0; in_data = 32'hAA;
    tick();
    in_data = 32'hBB;
    tick();
    vectors++;
    if ({count, out_data} !== {2'd2, 32'hAA}) begin
      errors++;
      $display("FAIL two_setup: got c=%0d d=%h, want c=2 d=000000aa", count, out_data);
    end
    reset = 1'b1; out_ready = 1'b1; in_data = 32'h55;
    tick();
    vectors++;
    if ({out_valid, in_ready, count, out_data} !== {1'b0, 1'b1, 2'd0, 32'h0}) begin
      errors++;
      $display("FAIL reset_two: got v=%b r=%b c=%0d d=%h, want v=0 r=1 c=0 d=00000000",
               out_valid, in_ready, count, out_data);
    end
    reset = 1'b0; in_valid = 1'b1; out_ready = 1'b0; in_data = 32'hCC;
    tick();
    vectors++;
    if ({out_valid, count, out_data} !== {1'b1, 2'd1, 32'hCC}) begin
      errors++;
      $display("FAIL after_reset: got v=%b c=%0d d=%h, want v=1 c=1 d=000000cc",
               out_valid, count, out_data);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    vectors++;
    if ({out_valid, count} !== {1'b0, 2'd0}) begin
      errors++;
      $display("FAIL after_reset_drain: got v=%b c=%0d, want v=0 c=0", out_valid, count);
    end
  endtask

  // Reference queue: accept when fewer than two held, take when non-empty.
  task automatic test_random();
    logic [WIDTH-1:0] q[$];
    bit acc;
    bit tk;
    void'($urandom(32'h5EED_0001));
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    reset = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = $urandom;
      acc = in_valid && (q.size() < 2);
      tk  = out_ready && (q.size() > 0);
      tick();
      if (tk) void'(q.pop_front());
      if (acc) q.push_back(in_data);
      vectors++;
      if ({out_valid, in_ready, count} !== {q.size() > 0, q.size() < 2, 2'(q.size())}) begin
        errors++;
        $display("FAIL rand_flags[%0d]: got v=%b r=%b c=%0d, want v=%b r=%b c=%0d",
                 n, out_valid, in_ready, count, q.size() > 0, q.size() < 2, q.size());
      end
      if (q.size() > 0) begin
        vectors++;
        if (out_data !== q[0]) begin
          errors++;
          $display("FAIL rand_data[%0d]: got %h, want %h", n, out_data, q[0]);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_single();
    test_fill_drain();
    test_stream();
    test_reset_in_two();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
